// File: rtl/mem_burst_echo_if.sv
// mem_burst_echo_if: burst capture/replay bus between a traffic source and the echo buffer
interface mem_burst_echo_if #(parameter int DW = 16);
  logic in_valid;
  logic [DW-1:0] in_data;
  logic out_valid;
  logic [DW-1:0] out_data;
  modport master(output in_valid, in_data, input out_valid, out_data);
  modport slave(input in_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/mem_burst_echo.sv
// mem_burst_echo: captures one contiguous burst and replays it in order as one contiguous burst
module mem_burst_echo #(
  parameter int DW = 16,
  parameter int DEPTH = 4096,
  parameter int AW = 12,
  parameter int GAP = 0
) (
  input logic clk,
  input logic rst_n,
  mem_burst_echo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, GAPW, DUMP} state_t;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [15:0] GAP_LD = 16'(GAP > 0 ? GAP - 1 : 0);
  state_t state, state_nx;
  logic [AW:0] wr_cnt, rd_ptr;
  logic [15:0] gap_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic we, done;
  assign we = bus.in_valid && (state == IDLE || (state == LOAD && wr_cnt != FULL));
  assign done = rd_ptr == wr_cnt;
  // next-state: capture until the first idle input cycle, optional gap, then replay
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.in_valid ? LOAD : IDLE;
      LOAD: state_nx = bus.in_valid ? LOAD : (GAP > 0 ? GAPW : DUMP);
      GAPW: state_nx = gap_cnt == '0 ? DUMP : GAPW;
      DUMP: state_nx = done ? IDLE : DUMP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // buffer array: not reset; words beyond capacity are never written
  always_ff @(posedge clk) begin
    if (we) mem[wr_cnt[AW-1:0]] <= bus.in_data;
  end
  // counters and registered read/output stage; output is zero whenever not replaying
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
      gap_cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
    end else begin
      if (we) wr_cnt <= wr_cnt + 1'b1;
      if (state == LOAD && !bus.in_valid) gap_cnt <= GAP_LD;
      else if (state == GAPW && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (state == DUMP && !done) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
        bus.out_data <= '0;
      end
      if (state == DUMP && done) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_burst_echo.sv
// tb_mem_burst_echo: three echo buffers (default, 8-deep, gap of 3) against a timestamp model
module tb_mem_burst_echo;
  logic clk = 0, rst_n = 0, iv = 0;
  logic [15:0] id = 0;
  int vectors = 0, miscompares = 0, cyc = 0, e = 0;
  int dep [3] = '{4096, 8, 4096};
  int gap [3] = '{0, 0, 3};
  int mode [3], n [3], start [3], tot [3], rise [3], s [3];
  logic [15:0] buf_m [3][4096];
  logic [15:0] first_d [3], last_d [3];
  logic pv [3];
  mem_burst_echo_if #(.DW(16)) b0 ();
  mem_burst_echo_if #(.DW(16)) b1 ();
  mem_burst_echo_if #(.DW(16)) b2 ();
  assign b0.in_valid = iv;
  assign b0.in_data = id;
  assign b1.in_valid = iv;
  assign b1.in_data = id;
  assign b2.in_valid = iv;
  assign b2.in_data = id;
  mem_burst_echo #(.DW(16), .DEPTH(4096), .AW(12), .GAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  mem_burst_echo #(.DW(16), .DEPTH(8), .AW(3), .GAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mem_burst_echo #(.DW(16), .DEPTH(4096), .AW(12), .GAP(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  always #5 clk = ~clk;
  // model: mode 0 idle, 1 capturing, 2 busy replaying words at edges start..start+n-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mode[i] = 0;
        n[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (mode[i] == 0) begin
          if (iv) begin
            buf_m[i][0] = id;
            n[i] = 1;
            mode[i] = 1;
          end
        end else if (mode[i] == 1) begin
          if (!iv) begin
            start[i] = cyc + 1 + gap[i];
            mode[i] = 2;
          end else if (n[i] < dep[i]) begin
            buf_m[i][n[i]] = id;
            n[i]++;
          end
        end else if (cyc >= start[i] + n[i]) mode[i] = 0;
      end
    end
  end
  task automatic cmp(input int i, input logic ov, input logic [15:0] od);
    logic ev;
    logic [15:0] ed;
    ev = mode[i] == 2 && cyc >= start[i] && cyc < start[i] + n[i];
    ed = ev ? buf_m[i][cyc - start[i]] : 16'h0;
    vectors++;
    if (ov !== ev || od !== ed) begin
      miscompares++;
      $display("FAIL cycle u%0d @%0d: out_valid=%0b out_data=%h, expected %0b %h", i, cyc, ov, od, ev, ed);
    end
    if (ov) begin
      tot[i]++;
      last_d[i] = od;
      if (!pv[i]) begin
        rise[i] = cyc;
        first_d[i] = od;
      end
    end
    pv[i] = ov;
  endtask
  always @(negedge clk) begin
    cmp(0, b0.out_valid, b0.out_data);
    cmp(1, b1.out_valid, b1.out_data);
    cmp(2, b2.out_valid, b2.out_data);
  end
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, act, act, exp, exp);
    end
  endtask
  task automatic put(input logic [15:0] d);
    @(negedge clk);
    iv = 1;
    id = d;
  endtask
  task automatic stop();
    @(negedge clk);
    iv = 0;
    id = 0;
  endtask
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic snap();
    for (int i = 0; i < 3; i++) s[i] = tot[i];
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      tot[i] = 0;
      rise[i] = -1;
      pv[i] = 0;
      first_d[i] = 0;
      last_d[i] = 0;
    end
    idle(3);
    chk("rst_v0", int'(b0.out_valid), 0);
    chk("rst_d0", int'(b0.out_data), 0);
    chk("rst_v1", int'(b1.out_valid), 0);
    chk("rst_d1", int'(b1.out_data), 0);
    chk("rst_v2", int'(b2.out_valid), 0);
    chk("rst_d2", int'(b2.out_data), 0);
    rst_n = 1;
    idle(2);
    snap();
    put(16'd1024); put(16'd512); stop(); e = cyc;
    idle(20);
    chk("t1_count", tot[0] - s[0], 2);
    chk("t1_rise", rise[0], e + 2);
    chk("t1_first", int'(first_d[0]), 1024);
    chk("t1_last", int'(last_d[0]), 512);
    snap();
    put(16'hFFFF); stop(); e = cyc;
    idle(20);
    chk("t2_count", tot[0] - s[0], 1);
    chk("t2_rise", rise[0], e + 2);
    chk("t2_data", int'(first_d[0]), 16'hFFFF);
    snap();
    for (int k = 1; k <= 10; k++) put(16'(k));
    stop();
    idle(25);
    chk("t3_sat_count", tot[1] - s[1], 8);
    chk("t3_sat_first", int'(first_d[1]), 1);
    chk("t3_sat_last", int'(last_d[1]), 8);
    chk("t3_full_count", tot[0] - s[0], 10);
    chk("t3_full_last", int'(last_d[0]), 10);
    snap();
    put(16'd7); put(16'd7); stop();
    idle(20);
    chk("t3_next_count", tot[1] - s[1], 2);
    chk("t3_next_first", int'(first_d[1]), 7);
    chk("t3_next_last", int'(last_d[1]), 7);
    snap();
    put(16'hA5A5); put(16'h5A5A); stop(); e = cyc;
    idle(20);
    chk("t4_rise", rise[2], e + 5);
    chk("t4_count", tot[2] - s[2], 2);
    chk("t4_first", int'(first_d[2]), 16'hA5A5);
    chk("t4_last", int'(last_d[2]), 16'h5A5A);
    chk("t4_nogap_rise", rise[0], e + 2);
    snap();
    put(16'd11); put(16'd22); put(16'd33); put(16'd44); stop(); e = cyc;
    idle(2);
    put(16'h1234); stop(); put(16'h1234); stop();
    idle(20);
    chk("t5_count", tot[0] - s[0], 4);
    chk("t5_first", int'(first_d[0]), 11);
    chk("t5_last", int'(last_d[0]), 44);
    snap();
    put(16'h0BEE); put(16'h0C0F); stop();
    idle(20);
    chk("t5_next_count", tot[0] - s[0], 2);
    chk("t5_next_first", int'(first_d[0]), 16'h0BEE);
    chk("t5_next_last", int'(last_d[0]), 16'h0C0F);
    for (int k = 101; k <= 106; k++) put(16'(k));
    stop(); e = cyc;
    idle(4);
    chk("t6_mid_valid", int'(b0.out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_valid", int'(b0.out_valid), 0);
    chk("t6_async_data", int'(b0.out_data), 0);
    idle(2);
    rst_n = 1;
    snap();
    idle(12);
    chk("t6_no_more", tot[0] - s[0], 0);
    snap();
    put(16'd201); put(16'd202); put(16'd203); stop();
    idle(20);
    chk("t6_count", tot[0] - s[0], 3);
    chk("t6_first", int'(first_d[0]), 201);
    chk("t6_last", int'(last_d[0]), 203);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
